// File: rtl/rgba_led_drv_pkg.sv
// rgba_led_drv_pkg: thermometer current codes, mA step sizes and code helpers
package rgba_led_drv_pkg;
  typedef logic [4:0] ma_t;
  localparam int NUM_LEGAL = 7;
  localparam logic [5:0] LEGAL_CODES [NUM_LEGAL] = '{6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b111111};
  localparam ma_t MA_STEP_FULL = 5'd4;
  localparam ma_t MA_STEP_HALF = 5'd2;
  function automatic logic therm_valid(input logic [5:0] code);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++) ok = ok | (code == LEGAL_CODES[i]);
    return ok;
  endfunction
  function automatic ma_t therm_to_ma(input logic [5:0] code, input logic mode);
    return therm_valid(code) ? ma_t'($countones(code)) * (mode ? MA_STEP_HALF : MA_STEP_FULL) : '0;
  endfunction
endpackage

// File: rtl/rgba_led_drv_if.sv
// rgba_led_drv_if: LED driver control/status bundle; cur_ma only with RGBA_LED_DRV_CUR_MON_EN
interface rgba_led_drv_if;
  logic curren;
  logic rgbleden;
  logic [2:0] rgb_pwm;
  logic [2:0] rgb;
  logic ready;
  logic [2:0] cfg_err;
`ifdef RGBA_LED_DRV_CUR_MON_EN
  logic [14:0] cur_ma;
  modport master (output curren, rgbleden, rgb_pwm, input rgb, ready, cfg_err, cur_ma);
  modport slave (input curren, rgbleden, rgb_pwm, output rgb, ready, cfg_err, cur_ma);
`else
  modport master (output curren, rgbleden, rgb_pwm, input rgb, ready, cfg_err);
  modport slave (input curren, rgbleden, rgb_pwm, output rgb, ready, cfg_err);
`endif
endinterface

// File: rtl/rgba_led_chan.sv
// rgba_led_chan: one LED sink channel; code check, current calc, registered active-low output
module rgba_led_chan
  import rgba_led_drv_pkg::*;
#(
  parameter logic [5:0] CODE = 6'b000001,
  parameter logic MODE = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic pwm,
  output logic rgb,
  output logic cfg_err
`ifdef RGBA_LED_DRV_CUR_MON_EN
  ,
  output ma_t cur_ma
`endif
);
  localparam ma_t MA = therm_to_ma(CODE, MODE);
  logic on;
  assign cfg_err = !therm_valid(CODE);
  assign on = en & pwm & (MA != '0);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rgb <= 1'b1;
    else rgb <= ~on;
`ifdef RGBA_LED_DRV_CUR_MON_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cur_ma <= '0;
    else cur_ma <= on ? MA : '0;
`endif
endmodule

// File: rtl/rgba_led_drv.sv
// rgba_led_drv: 3-channel RGB LED sink driver with current-reference settle timer
// Optional per-channel mA monitor output enabled by RGBA_LED_DRV_CUR_MON_EN.
module rgba_led_drv
  import rgba_led_drv_pkg::*;
#(
  parameter logic CURRENT_MODE = 1'b0,
  parameter logic [5:0] RGB0_CURRENT = 6'b000001,
  parameter logic [5:0] RGB1_CURRENT = 6'b000001,
  parameter logic [5:0] RGB2_CURRENT = 6'b000001,
  parameter int STARTUP_CYCLES = 1200
) (
  input logic clk,
  input logic reset_n,
  rgba_led_drv_if.slave bus
);
  localparam logic [5:0] CODES [3] = '{RGB0_CURRENT, RGB1_CURRENT, RGB2_CURRENT};
  localparam logic [15:0] LAST = 16'(STARTUP_CYCLES - 1);
  logic [15:0] cnt;
  logic ready;
  logic [2:0] rgb;
  logic [2:0] cfg_err;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      ready <= 1'b0;
    end else if (!bus.curren) begin
      cnt <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      cnt <= cnt + 16'd1;
      ready <= (cnt == LAST);
    end
`ifdef RGBA_LED_DRV_CUR_MON_EN
  ma_t ma [3];
  assign bus.cur_ma = {ma[2], ma[1], ma[0]};
`endif
  for (genvar n = 0; n < 3; n++) begin : g_chan
    rgba_led_chan #(.CODE(CODES[n]), .MODE(CURRENT_MODE)) u_chan (
      .clk(clk),
      .reset_n(reset_n),
      .en(ready & bus.rgbleden),
      .pwm(bus.rgb_pwm[n]),
      .rgb(rgb[n]),
      .cfg_err(cfg_err[n])
`ifdef RGBA_LED_DRV_CUR_MON_EN
      ,
      .cur_ma(ma[n])
`endif
    );
  end
  assign bus.rgb = rgb;
  assign bus.cfg_err = cfg_err;
  assign bus.ready = ready;
endmodule

// File: tb/tb_rgba_led_drv.sv
// tb_rgba_led_drv: scoreboard bench for two driver configs (full/half current, illegal code)
module tb_rgba_led_drv;
  localparam int S = 4;
  localparam logic [2:0] MASK_A = 3'b101;
  localparam logic [2:0] MASK_B = 3'b111;
  typedef struct packed {
    logic [2:0] rgb_a;
    logic [2:0] rgb_b;
    logic rdy;
    logic [14:0] cur_a;
    logic [14:0] cur_b;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic curren = 1'b0;
  logic rgbleden = 1'b0;
  logic [2:0] rgb_pwm = 3'b000;
  int nvec = 0;
  int nfail = 0;
  int streak = 0;
  logic m_ready = 1'b0;
  exp_t q[$];
  rgba_led_drv_if ifa();
  rgba_led_drv_if ifb();
  assign ifa.curren = curren;
  assign ifa.rgbleden = rgbleden;
  assign ifa.rgb_pwm = rgb_pwm;
  assign ifb.curren = curren;
  assign ifb.rgbleden = rgbleden;
  assign ifb.rgb_pwm = rgb_pwm;
  rgba_led_drv #(.CURRENT_MODE(1'b0), .RGB0_CURRENT(6'b000111), .RGB1_CURRENT(6'b000101), .RGB2_CURRENT(6'b111111), .STARTUP_CYCLES(S)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  rgba_led_drv #(.CURRENT_MODE(1'b1), .RGB0_CURRENT(6'b000111), .STARTUP_CYCLES(S)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    streak = 0;
    m_ready = 1'b0;
    q.delete();
  endtask
  task automatic step(input logic c, input logic e, input logic [2:0] p);
    exp_t x;
    logic [2:0] ona;
    logic [2:0] onb;
    curren = c;
    rgbleden = e;
    rgb_pwm = p;
    ona = {3{m_ready & e}} & p & MASK_A;
    onb = {3{m_ready & e}} & p & MASK_B;
    streak = c ? (streak < S ? streak + 1 : streak) : 0;
    x.rdy = (streak >= S);
    x.rgb_a = ~ona;
    x.rgb_b = ~onb;
    x.cur_a = {ona[2] ? 5'd24 : 5'd0, 5'd0, ona[0] ? 5'd12 : 5'd0};
    x.cur_b = {onb[2] ? 5'd2 : 5'd0, onb[1] ? 5'd2 : 5'd0, onb[0] ? 5'd6 : 5'd0};
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("rgb_a", 32'(ifa.rgb), 32'(x.rgb_a));
    chk("rgb_b", 32'(ifb.rgb), 32'(x.rgb_b));
    chk("ready_a", 32'(ifa.ready), 32'(x.rdy));
    chk("ready_b", 32'(ifb.ready), 32'(x.rdy));
`ifdef RGBA_LED_DRV_CUR_MON_EN
    chk("cur_ma_a", 32'(ifa.cur_ma), 32'(x.cur_a));
    chk("cur_ma_b", 32'(ifb.cur_ma), 32'(x.cur_b));
`endif
    m_ready = x.rdy;
  endtask
  initial begin
    curren = 1'b1;
    rgbleden = 1'b1;
    rgb_pwm = 3'b111;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_rgb_a", 32'(ifa.rgb), 32'h7);
    chk("rst_rgb_b", 32'(ifb.rgb), 32'h7);
    chk("rst_ready_a", 32'(ifa.ready), 32'h0);
    chk("rst_ready_b", 32'(ifb.ready), 32'h0);
    chk("cfg_err_a", 32'(ifa.cfg_err), 32'h2);
    chk("cfg_err_b", 32'(ifb.cfg_err), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_rgb_a", 32'(ifa.rgb), 32'h7);
    chk("rst_hold_ready_a", 32'(ifa.ready), 32'h0);
    curren = 1'b0;
    #2 reset_n = 1'b1;
    model_reset();
    step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b1, 3'b111);
    for (int i = 0; i < S + 1; i++) step(1'b1, 1'b1, 3'b001);
    step(1'b1, 1'b0, 3'b001);
    step(1'b1, 1'b1, 3'b001);
    step(1'b1, 1'b1, 3'b010);
    step(1'b1, 1'b1, 3'b010);
    step(1'b1, 1'b1, 3'b111);
    step(1'b1, 1'b1, 3'b110);
    step(1'b1, 1'b1, 3'b101);
    step(1'b0, 1'b1, 3'b111);
    for (int i = 0; i < S + 2; i++) step(1'b1, 1'b1, 3'b111);
    for (int i = 0; i < 24; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    for (int i = 0; i < S + 1; i++) step(1'b1, 1'b1, 3'b111);
    #3 reset_n = 1'b0;
    #1;
    chk("midrst_rgb_a", 32'(ifa.rgb), 32'h7);
    chk("midrst_rgb_b", 32'(ifb.rgb), 32'h7);
    chk("midrst_ready_a", 32'(ifa.ready), 32'h0);
    chk("midrst_cfg_err_a", 32'(ifa.cfg_err), 32'h2);
    #2 reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < S + 3; i++) step(1'b1, 1'b1, 3'b111);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
